// File: rtl/axi4_lite_master_arbiter_pkg.sv
// Shared types and defaults for the two-requester AXI4-Lite master arbiter:
// FSM state encoding, AXI response codes and default bus widths.
package Axi4LiteGlobalsPkg;

    localparam int AXI_ADDR_WIDTH     = 32;
    localparam int AXI_DATA_WIDTH     = 32;
    localparam int AXI_TIMEOUT_CYCLES = 256;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RSP
    } arb_state_e;

endpackage

// File: rtl/axi4_lite_rr_arbiter.sv
// Two-way round-robin arbiter: on a tie it grants the requester preferred by
// rr_ptr, which always points at the requester that was not granted last.
module axi4_lite_rr_arbiter (
    input  logic       aclk,
    input  logic       areset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic rr_ptr;

    // NOTE: combinational block assigns its output first so no branch can infer a latch.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = rr_ptr ? 2'b10 : 2'b01;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rr_ptr <= 1'b0;
        end else if (accept) begin
            rr_ptr <= grant[0];
        end
    end

endmodule

// File: rtl/axi4_lite_master_arbiter.sv
// Shares one AXI4-Lite master port between two requesters, one transaction at a time.
// Define AXI4LITE_ARB_TIMEOUT_EN to add the sticky timeout_err watchdog output.
module axi4_lite_master_arbiter
    import Axi4LiteGlobalsPkg::*;
#(
    parameter int ADDR_WIDTH     = AXI_ADDR_WIDTH,
    parameter int DATA_WIDTH     = AXI_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = AXI_TIMEOUT_CYCLES
) (
    input  logic                    aclk,
    input  logic                    areset,

    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic                    req0_write,
    input  logic [ADDR_WIDTH-1:0]   req0_addr,
    input  logic [DATA_WIDTH-1:0]   req0_wdata,
    input  logic [DATA_WIDTH/8-1:0] req0_wstrb,
    output logic                    rsp0_valid,
    input  logic                    rsp0_ready,
    output logic [DATA_WIDTH-1:0]   rsp0_rdata,
    output logic [1:0]              rsp0_resp,

    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic                    req1_write,
    input  logic [ADDR_WIDTH-1:0]   req1_addr,
    input  logic [DATA_WIDTH-1:0]   req1_wdata,
    input  logic [DATA_WIDTH/8-1:0] req1_wstrb,
    output logic                    rsp1_valid,
    input  logic                    rsp1_ready,
    output logic [DATA_WIDTH-1:0]   rsp1_rdata,
    output logic [1:0]              rsp1_resp,

    output logic                    awvalid,
    input  logic                    awready,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic                    wvalid,
    input  logic                    wready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    bvalid,
    output logic                    bready,
    input  logic [1:0]              bresp,
    output logic                    arvalid,
    input  logic                    arready,
    output logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    rvalid,
    output logic                    rready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp
`ifdef AXI4LITE_ARB_TIMEOUT_EN
    ,
    output logic                    timeout_err
`endif
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_e              state, next_state;
    logic                    owner;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_WIDTH-1:0]   wstrb_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              resp_q;
    logic                    aw_done, w_done;
    logic [1:0]              grant;
    logic                    accept;

    logic                    sel_write;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [STRB_WIDTH-1:0]   sel_wstrb;

    axi4_lite_rr_arbiter u_arb (
        .aclk   (aclk),
        .areset (areset),
        .req    ({req1_valid, req0_valid}),
        .accept (accept),
        .grant  (grant)
    );

    assign accept     = (state == IDLE) && (grant != 2'b00);
    assign req0_ready = accept && grant[0];
    assign req1_ready = accept && grant[1];

    assign sel_write = grant[1] ? req1_write : req0_write;
    assign sel_addr  = grant[1] ? req1_addr  : req0_addr;
    assign sel_wdata = grant[1] ? req1_wdata : req0_wdata;
    assign sel_wstrb = grant[1] ? req1_wstrb : req0_wstrb;

    // AW and W are tracked separately so each valid drops on its own handshake.
    assign awvalid = (state == WR_ADDR_DATA) && !aw_done;
    assign wvalid  = (state == WR_ADDR_DATA) && !w_done;
    assign bready  = (state == WR_RESP);
    assign arvalid = (state == RD_ADDR);
    assign rready  = (state == RD_DATA);
    assign awaddr  = addr_q;
    assign araddr  = addr_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;

    assign rsp0_valid = (state == RSP) && !owner;
    assign rsp1_valid = (state == RSP) &&  owner;
    assign rsp0_rdata = rdata_q;
    assign rsp1_rdata = rdata_q;
    assign rsp0_resp  = resp_q;
    assign rsp1_resp  = resp_q;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:         if (accept) next_state = sel_write ? WR_ADDR_DATA : RD_ADDR;
            WR_ADDR_DATA: if ((aw_done || awready) && (w_done || wready)) next_state = WR_RESP;
            WR_RESP:      if (bvalid) next_state = RSP;
            RD_ADDR:      if (arready) next_state = RD_DATA;
            RD_DATA:      if (rvalid) next_state = RSP;
            RSP:          if (owner ? rsp1_ready : rsp0_ready) next_state = IDLE;
            default:      next_state = IDLE;
        endcase
    end

    // NOTE: payload registers are reset as well so every output reads 0 right after areset.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state   <= IDLE;
            owner   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            resp_q  <= RESP_OKAY;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner   <= grant[1];
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        wstrb_q <= sel_wstrb;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                WR_ADDR_DATA: begin
                    if (awvalid && awready) aw_done <= 1'b1;
                    if (wvalid && wready)   w_done  <= 1'b1;
                end
                WR_RESP: begin
                    if (bvalid) begin
                        resp_q  <= bresp;
                        rdata_q <= '0;
                    end
                end
                RD_DATA: begin
                    if (rvalid) begin
                        resp_q  <= rresp;
                        rdata_q <= rdata;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef AXI4LITE_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt;
    logic             busy;

    assign busy = (state == WR_ADDR_DATA) || (state == WR_RESP) ||
                  (state == RD_ADDR)      || (state == RD_DATA);

    // Watchdog only flags; the transaction itself keeps running untouched.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else if (next_state == RSP) begin
            wd_cnt <= '0;
        end else if (busy && (wd_cnt != CNT_W'(TIMEOUT_CYCLES))) begin
            wd_cnt <= wd_cnt + 1'b1;
            if (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) timeout_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_axi4_lite_master_arbiter.sv
// Directed bench for axi4_lite_master_arbiter; the watchdog scenario is built
// only when AXI4LITE_ARB_TIMEOUT_EN is defined.
module tb_axi4_lite_master_arbiter;

    logic        aclk = 1'b0;
    logic        areset;

    logic        req0_valid, req0_ready, req0_write;
    logic [31:0] req0_addr, req0_wdata;
    logic [3:0]  req0_wstrb;
    logic        rsp0_valid, rsp0_ready;
    logic [31:0] rsp0_rdata;
    logic [1:0]  rsp0_resp;

    logic        req1_valid, req1_ready, req1_write;
    logic [31:0] req1_addr, req1_wdata;
    logic [3:0]  req1_wstrb;
    logic        rsp1_valid, rsp1_ready;
    logic [31:0] rsp1_rdata;
    logic [1:0]  rsp1_resp;

    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
`ifdef AXI4LITE_ARB_TIMEOUT_EN
    logic        timeout_err;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    int b_count      = 0;

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        if (!areset && bvalid && bready) b_count++;
    end

    axi4_lite_master_arbiter #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_write  (req0_write),
        .req0_addr   (req0_addr),
        .req0_wdata  (req0_wdata),
        .req0_wstrb  (req0_wstrb),
        .rsp0_valid  (rsp0_valid),
        .rsp0_ready  (rsp0_ready),
        .rsp0_rdata  (rsp0_rdata),
        .rsp0_resp   (rsp0_resp),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_write  (req1_write),
        .req1_addr   (req1_addr),
        .req1_wdata  (req1_wdata),
        .req1_wstrb  (req1_wstrb),
        .rsp1_valid  (rsp1_valid),
        .rsp1_ready  (rsp1_ready),
        .rsp1_rdata  (rsp1_rdata),
        .rsp1_resp   (rsp1_resp),
        .awvalid     (awvalid),
        .awready     (awready),
        .awaddr      (awaddr),
        .wvalid      (wvalid),
        .wready      (wready),
        .wdata       (wdata),
        .wstrb       (wstrb),
        .bvalid      (bvalid),
        .bready      (bready),
        .bresp       (bresp),
        .arvalid     (arvalid),
        .arready     (arready),
        .araddr      (araddr),
        .rvalid      (rvalid),
        .rready      (rready),
        .rdata       (rdata),
        .rresp       (rresp)
`ifdef AXI4LITE_ARB_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_write = 0; req0_addr = 0; req0_wdata = 0; req0_wstrb = 0;
        req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0; req1_wstrb = 0;
        rsp0_ready = 0; rsp1_ready = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    endtask

    task automatic do_reset();
        areset = 1;
        tick();
        tick();
        areset = 0;
        tick();
    endtask

    task automatic test_reset();
        logic [8:0] flags;
        idle_inputs();
        areset = 1;
        tick();
        tick();
        flags = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, awvalid, wvalid, bready, arvalid, rready};
        tests_run++;
        if (flags !== 9'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected %b", flags, 9'b0);
        end
        tests_run++;
        if ({awaddr, wdata, rsp0_rdata, rsp0_resp} !== 98'b0) begin
            tests_failed++;
            $display("FAIL reset_payload: got %h/%h/%h/%h expected all zero", awaddr, wdata, rsp0_rdata, rsp0_resp);
        end
`ifdef AXI4LITE_ARB_TIMEOUT_EN
        tests_run++;
        if (timeout_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_timeout_err: got %b expected 0", timeout_err);
        end
`endif
        areset = 0;
        tick();
    endtask

    task automatic test_write_zero_wait();
        awready = 1; wready = 1; bvalid = 1; bresp = 2'b00;
        req0_valid = 1; req0_write = 1; req0_addr = 32'h10; req0_wdata = 32'hA5A5A5A5; req0_wstrb = 4'hF;
        settle();
        tests_run++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            tests_failed++;
            $display("FAIL wr0_accept: got %b expected 10", {req0_ready, req1_ready});
        end
        tick();
        req0_valid = 0;
        tests_run++;
        if ({awvalid, wvalid, awaddr, wdata, wstrb} !== {1'b1, 1'b1, 32'h10, 32'hA5A5A5A5, 4'hF}) begin
            tests_failed++;
            $display("FAIL wr0_aw_w: got %b%b %h %h %h expected 11 00000010 a5a5a5a5 f",
                     awvalid, wvalid, awaddr, wdata, wstrb);
        end
        tick();
        tests_run++;
        if ({awvalid, wvalid, bready, rsp0_valid} !== 4'b0010) begin
            tests_failed++;
            $display("FAIL wr0_b_phase: got %b expected 0010", {awvalid, wvalid, bready, rsp0_valid});
        end
        tick();
        tests_run++;
        if ({rsp0_valid, rsp1_valid, rsp0_resp, rsp0_rdata} !== {1'b1, 1'b0, 2'b00, 32'h0}) begin
            tests_failed++;
            $display("FAIL wr0_rsp_cycle3: got %b%b %h %h expected 10 0 00000000",
                     rsp0_valid, rsp1_valid, rsp0_resp, rsp0_rdata);
        end
        awready = 0; wready = 0; bvalid = 0;
        rsp0_ready = 1;
        tick();
        tests_run++;
        if (rsp0_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL wr0_rsp_drop: got %b expected 0", rsp0_valid);
        end
        rsp0_ready = 0;
    endtask

    task automatic test_write_w_delayed();
        int b_start;
        b_start = b_count;
        awready = 1; wready = 0; bvalid = 0;
        req0_valid = 1; req0_write = 1; req0_addr = 32'h20; req0_wdata = 32'h12345678; req0_wstrb = 4'h3;
        settle();
        tick();
        req0_valid = 0;
        tests_run++;
        if ({awvalid, wvalid} !== 2'b11) begin
            tests_failed++;
            $display("FAIL wdly_both_valid: got %b expected 11", {awvalid, wvalid});
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if ({awvalid, wvalid, wdata} !== {1'b0, 1'b1, 32'h12345678}) begin
                tests_failed++;
                $display("FAIL wdly_w_held[%0d]: got %b%b %h expected 01 12345678", i, awvalid, wvalid, wdata);
            end
            tick();
        end
        wready = 1;
        settle();
        tests_run++;
        if ({awvalid, wvalid, wdata} !== {1'b0, 1'b1, 32'h12345678}) begin
            tests_failed++;
            $display("FAIL wdly_w_final: got %b%b %h expected 01 12345678", awvalid, wvalid, wdata);
        end
        tick();
        wready = 0;
        tests_run++;
        if ({awvalid, wvalid, bready} !== 3'b001) begin
            tests_failed++;
            $display("FAIL wdly_b_phase: got %b expected 001", {awvalid, wvalid, bready});
        end
        bvalid = 1; bresp = 2'b10;
        tick();
        tests_run++;
        if ({rsp0_valid, rsp0_resp} !== 3'b110) begin
            tests_failed++;
            $display("FAIL wdly_rsp: got %b %b expected 1 10", rsp0_valid, rsp0_resp);
        end
        tick();
        tick();
        tests_run++;
        if (b_count - b_start !== 1) begin
            tests_failed++;
            $display("FAIL wdly_b_count: got %0d expected 1", b_count - b_start);
        end
        bvalid = 0; awready = 0;
        rsp0_ready = 1;
        tick();
        rsp0_ready = 0;
    endtask

    task automatic test_round_robin();
        logic exp_order [3];
        logic g;
        exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0;
        do_reset();
        arready = 1; rvalid = 1; rresp = 2'b00; rdata = 32'h5555;
        rsp0_ready = 1; rsp1_ready = 1;
        req0_write = 0; req0_addr = 32'h100; req0_valid = 1;
        req1_write = 0; req1_addr = 32'h200; req1_valid = 1;
        for (int r = 0; r < 3; r++) begin
            g = exp_order[r];
            settle();
            tests_run++;
            if ({req1_ready, req0_ready} !== (g ? 2'b10 : 2'b01)) begin
                tests_failed++;
                $display("FAIL rr_grant[%0d]: got %b expected %b", r, {req1_ready, req0_ready}, g ? 2'b10 : 2'b01);
            end
            tick();
            tests_run++;
            if ({arvalid, araddr, req1_ready, req0_ready} !== {1'b1, (g ? 32'h200 : 32'h100), 2'b00}) begin
                tests_failed++;
                $display("FAIL rr_ar[%0d]: got %b %h %b%b expected 1 %h 00", r, arvalid, araddr,
                         req1_ready, req0_ready, g ? 32'h200 : 32'h100);
            end
            tick();
            tick();
            tests_run++;
            if ({rsp1_valid, rsp0_valid} !== (g ? 2'b10 : 2'b01)) begin
                tests_failed++;
                $display("FAIL rr_rsp_owner[%0d]: got %b expected %b", r, {rsp1_valid, rsp0_valid}, g ? 2'b10 : 2'b01);
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_read_stall();
        arready = 1; rvalid = 1; rdata = 32'hDEAD; rresp = 2'b10;
        rsp1_ready = 0;
        req1_valid = 1; req1_write = 0; req1_addr = 32'h40;
        settle();
        tests_run++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            tests_failed++;
            $display("FAIL rd1_accept: got %b expected 10", {req1_ready, req0_ready});
        end
        tick();
        req1_valid = 0;
        tick();
        tick();
        tests_run++;
        if ({rsp1_valid, rsp0_valid, rsp1_rdata, rsp1_resp} !== {2'b10, 32'hDEAD, 2'b10}) begin
            tests_failed++;
            $display("FAIL rd1_rsp: got %b%b %h %b expected 10 0000dead 10", rsp1_valid, rsp0_valid, rsp1_rdata, rsp1_resp);
        end
        rdata = 32'hBEEF; rresp = 2'b00;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if ({rsp1_valid, rsp1_rdata, rsp1_resp} !== {1'b1, 32'hDEAD, 2'b10}) begin
                tests_failed++;
                $display("FAIL rd1_stall[%0d]: got %b %h %b expected 1 0000dead 10", i, rsp1_valid, rsp1_rdata, rsp1_resp);
            end
        end
        rsp1_ready = 1;
        tick();
        tests_run++;
        if (rsp1_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd1_rsp_drop: got %b expected 0", rsp1_valid);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        logic [8:0] flags;
        arready = 1; rvalid = 0;
        req0_valid = 1; req0_write = 0; req0_addr = 32'h80;
        settle();
        tick();
        req0_valid = 0;
        tick();
        tests_run++;
        if ({arvalid, rready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL mid_rd_data: got %b expected 01", {arvalid, rready});
        end
        areset = 1;
        rvalid = 1; rdata = 32'h1234;
        tick();
        flags = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, awvalid, wvalid, bready, arvalid, rready};
        tests_run++;
        if ({flags, araddr, rsp0_rdata} !== 73'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs: got %b %h %h expected all zero", flags, araddr, rsp0_rdata);
        end
        areset = 0;
        tick();
        tick();
        tests_run++;
        if ({rsp0_valid, rsp1_valid, arvalid, rready} !== 4'b0) begin
            tests_failed++;
            $display("FAIL mid_no_response: got %b expected 0000", {rsp0_valid, rsp1_valid, arvalid, rready});
        end
        rvalid = 0; arready = 0;
        awready = 1; wready = 1; bvalid = 1; bresp = 2'b00;
        req1_valid = 1; req1_write = 1; req1_addr = 32'h84; req1_wdata = 32'hCAFEF00D; req1_wstrb = 4'hF;
        settle();
        tests_run++;
        if (req1_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_new_accept: got %b expected 1", req1_ready);
        end
        tick();
        req1_valid = 0;
        tick();
        tick();
        tests_run++;
        if ({rsp1_valid, rsp0_valid, rsp1_resp} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL mid_new_rsp: got %b%b %b expected 10 00", rsp1_valid, rsp0_valid, rsp1_resp);
        end
        rsp1_ready = 1;
        tick();
        idle_inputs();
    endtask

`ifdef AXI4LITE_ARB_TIMEOUT_EN
    task automatic test_timeout();
        awready = 1; wready = 1; bvalid = 0;
        req0_valid = 1; req0_write = 1; req0_addr = 32'h90; req0_wdata = 32'h0F0F0F0F; req0_wstrb = 4'hF;
        settle();
        tick();
        req0_valid = 0;
        for (int i = 0; i < 7; i++) tick();
        tests_run++;
        if (timeout_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL to_cycle7: got %b expected 0", timeout_err);
        end
        tick();
        tests_run++;
        if (timeout_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL to_cycle8: got %b expected 1", timeout_err);
        end
        for (int i = 0; i < 12; i++) tick();
        tests_run++;
        if ({bready, rsp0_valid, timeout_err} !== 3'b101) begin
            tests_failed++;
            $display("FAIL to_still_waiting: got %b expected 101", {bready, rsp0_valid, timeout_err});
        end
        bvalid = 1;
        tick();
        tests_run++;
        if ({rsp0_valid, rsp0_resp, timeout_err} !== 4'b1001) begin
            tests_failed++;
            $display("FAIL to_completes: got %b %b %b expected 1 00 1", rsp0_valid, rsp0_resp, timeout_err);
        end
        bvalid = 0;
        rsp0_ready = 1;
        tick();
        idle_inputs();
    endtask
`endif

    initial begin
        areset = 1;
        idle_inputs();
        test_reset();
        test_write_zero_wait();
        test_write_w_delayed();
        test_round_robin();
        test_read_stall();
        test_reset_mid();
`ifdef AXI4LITE_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/axi4_lite_master_arbiter.md
AXI4_LITE_MASTER_ARBITER -- requirements
Module: axi4_lite_master_arbiter

Interface
- REQ-001 The clock SHALL be aclk; reset SHALL be areset, asynchronous, active-high; all logic SHALL be single-clock.
- REQ-002 ADDR_WIDTH SHALL default to 32 and set the address width.
- REQ-003 DATA_WIDTH SHALL default to 32 and set the data width; the strobe width is DATA_WIDTH/8.
- REQ-004 TIMEOUT_CYCLES SHALL default to 256 and set the watchdog limit.
- REQ-005 aclk SHALL be an input, 1 bit: the clock.
- REQ-006 areset SHALL be an input, 1 bit: the reset.
- REQ-007 reqN_valid SHALL be an input and reqN_ready an output, 1 bit each (N=0,1): the request handshake.
- REQ-008 reqN_write SHALL be an input, 1 bit: 1 = write, 0 = read.
- REQ-009 reqN_addr, reqN_wdata and reqN_wstrb SHALL be inputs, ADDR, DATA and STRB widths: the request payload.
- REQ-010 rspN_valid SHALL be an output and rspN_ready an input, 1 bit each: the response handshake.
- REQ-011 rspN_rdata and rspN_resp SHALL be outputs, DATA and 2 bits: the response payload.
- REQ-012 awvalid SHALL be an output, awready an input and awaddr an output, 1/1/ADDR bits: the AW channel.
- REQ-013 wvalid SHALL be an output, wready an input and wdata/wstrb outputs, 1/1/DATA/STRB bits: the W channel.
- REQ-014 bvalid SHALL be an input, bready an output and bresp an input, 1/1/2 bits: the B channel.
- REQ-015 arvalid SHALL be an output, arready an input and araddr an output, 1/1/ADDR bits: the AR channel.
- REQ-016 rvalid SHALL be an input, rready an output and rdata/rresp inputs, 1/1/DATA/2 bits: the R channel.
- REQ-017 timeout_err SHALL be an output, 1 bit, sticky: watchdog expired (present only with the macro).

Function
- REQ-018 The block SHALL share one AXI4-Lite master port between two requesters, with one outstanding transaction at a time.
- REQ-019 The FSM states SHALL be IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA and RSP.
- REQ-020 In IDLE, the block SHALL grant round-robin; on a tie it SHALL grant the requester not granted last; after reset it SHALL prefer requester 0.
- REQ-021 reqN_ready SHALL be high only in IDLE for the granted N, so acceptance completes in one cycle; the payload SHALL be registered on acceptance.
- REQ-022 A write SHALL go to WR_ADDR_DATA the next cycle with awvalid=wvalid=1.
- REQ-023 In WR_ADDR_DATA, each valid SHALL drop independently after its ready is sampled high, and the FSM SHALL move to WR_RESP once both AW and W are accepted, in any order or in the same cycle.
- REQ-024 In WR_RESP, bready SHALL be 1; on bvalid the FSM SHALL capture bresp, set rdata=0 and go to RSP.
- REQ-025 A read SHALL go to RD_ADDR with arvalid=1; on arready the FSM SHALL go to RD_DATA with rready=1; on rvalid it SHALL capture rdata/rresp and go to RSP.
- REQ-026 In RSP, rspN_valid SHALL be high for the owning requester only, and the payload SHALL be held stable until rspN_ready; the FSM SHALL then return to IDLE.
- REQ-027 Every AXI valid SHALL stay asserted until its handshake completes, and address/data SHALL stay stable while valid.
- REQ-028 Minimum latency from request acceptance to rspN_valid SHALL be 3 cycles with zero-wait ready/valid.

Reset
- REQ-029 On areset, the FSM SHALL go to IDLE and all valid/ready outputs, timeout_err and the last-grant pointer SHALL clear to 0.
- REQ-030 A reset mid-transaction SHALL abandon the transaction with no response issued.

Configuration
- REQ-031 With AXI4LITE_ARB_TIMEOUT_EN defined, a counter SHALL count cycles spent in WR_ADDR_DATA, WR_RESP, RD_ADDR and RD_DATA, and set timeout_err on reaching TIMEOUT_CYCLES.
- REQ-032 When the timeout fires, the transaction SHALL continue unaltered.
- REQ-033 The counter SHALL clear on entry to RSP.
- REQ-034 Without AXI4LITE_ARB_TIMEOUT_EN, the counter and timeout_err SHALL be absent.

Structure
- REQ-035 The state enum, the response codes (OKAY=0, SLVERR=2) and the default widths SHALL be placed in Axi4LiteGlobalsPkg.
- REQ-036 The two-way round-robin arbiter SHALL be a sub-module named axi4_lite_rr_arbiter.

Verification
- REQ-037 Write req0 with addr=0x10, wdata=0xA5A5A5A5, and awready/wready/bvalid held high -> AW+W in one cycle, rsp0_resp=0, rsp0_valid 3 cycles after acceptance.
- REQ-038 Write with wready delayed 4 cycles after awready -> awvalid drops after the AW handshake, wvalid is held with stable wdata, and only one B is consumed.
- REQ-039 req0 and req1 asserted together, three times -> grant order 0,1,0, with no overlap on AXI.
- REQ-040 Read with rresp=2 and rdata=0xDEAD -> rsp1_rdata=0xDEAD, rsp1_resp=2, held through 5 stall cycles of rsp1_ready=0.
- REQ-041 With the macro defined and TIMEOUT_CYCLES=8, bvalid withheld for 20 cycles -> timeout_err=1 at cycle 8, and the transaction completes when bvalid arrives.
- REQ-042 areset asserted during RD_DATA -> all outputs are 0 next edge, and IDLE accepts a new request.
